sd_seq_rx: RTL

Synthesizable consumer-side endpoint for an srdy/drdy channel carrying an incrementing data sequence. It is the receiving counterpart of a sequence generator. It applies a programmable 8-bit drdy backpressure pattern, checks each accepted word against the expected next value, and keeps saturating ok/error counters plus first-error capture. It terminates the output side of FIFOs and pipelines (e.g. sd_fifo_c) in on-chip self-test and FPGA bring-up, where the simulation-only checker cannot be used.

---
 rtl/sd_seq_pkg.sv | 20 ++
 rtl/sd_sat_cnt.sv | 25 ++
 rtl/sd_seq_rx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sd_seq_pkg.sv
// rtl/sd_seq_pkg.sv - shared types and helpers for the sd sequence generator/checker
package sd_seq_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } seq_state_t;

  localparam logic [7:0] PAT_DEFAULT = 8'hFF;

  // Increment v but hold at the w-bit all-ones value (w in 1..32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [32:0] top;
    top = (33'd1 << w) - 33'd1;
    if ({1'b0, v} >= top) return v;
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/sd_sat_cnt.sv
// rtl/sd_sat_cnt.sv - saturating up-counter with synchronous clear
module sd_sat_cnt
  import sd_seq_pkg::*;
#(
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  output logic [cnt_width-1:0] cnt
);

  logic [cnt_width-1:0] cnt_q;

  // Clear wins over inc; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (inc)   cnt_q <= cnt_width'(sat_inc(32'(cnt_q), cnt_width));
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sd_seq_rx.sv
// rtl/sd_seq_rx.sv - srdy/drdy sink that checks an incrementing data sequence
module sd_seq_rx
  import sd_seq_pkg::*;
#(
  parameter int width       = 8,
  parameter int cnt_width   = 16,
  parameter int sync_any    = 1,
  parameter int halt_on_err = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_srdy,
  output logic                 c_drdy,
  input  logic [width-1:0]     c_data,
  input  logic                 pat_load,
  input  logic [7:0]           drdy_pat,
  input  logic                 clear,
  output logic [cnt_width-1:0] ok_cnt,
  output logic [cnt_width-1:0] err_cnt,
  output logic                 err,
  output logic [width-1:0]     err_exp,
  output logic [width-1:0]     err_got,
  output logic                 locked
);

  localparam seq_state_t     RST_STATE = (sync_any != 0) ? SYNC : CHECK;
  localparam logic [width-1:0] ONE     = 1;

  logic [7:0]       pat_q;
  seq_state_t       state_q, state_d;
  logic [width-1:0] exp_q, exp_d;
  logic             err_q, err_d;
  logic [width-1:0] err_exp_q, err_exp_d;
  logic [width-1:0] err_got_q, err_got_d;
  logic             ok_inc, err_inc;
  logic             xfer;

  assign c_drdy = pat_q[0] & (state_q != HALT);
  assign xfer   = c_srdy & c_drdy;
  assign locked = (state_q == CHECK);

  // Backpressure pattern: rotate right each cycle, a load replaces it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pat_q <= PAT_DEFAULT;
    else if (pat_load) pat_q <= drdy_pat;
    else               pat_q <= {pat_q[0], pat_q[7:1]};
  end

  // Checker state and first-error capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RST_STATE;
      exp_q     <= '0;
      err_q     <= 1'b0;
      err_exp_q <= '0;
      err_got_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      err_exp_q <= err_exp_d;
      err_got_q <= err_got_d;
    end
  end

  // Next-state: seed, compare, resync on mismatch; clear overrides any transfer.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    err_d     = err_q;
    err_exp_d = err_exp_q;
    err_got_d = err_got_q;
    ok_inc    = 1'b0;
    err_inc   = 1'b0;
    if (clear) begin
      state_d   = RST_STATE;
      exp_d     = '0;
      err_d     = 1'b0;
      err_exp_d = '0;
      err_got_d = '0;
    end else if (xfer) begin
      case (state_q)
        SYNC: begin
          exp_d   = c_data + ONE;
          ok_inc  = 1'b1;
          state_d = CHECK;
        end
        CHECK: begin
          if (c_data == exp_q) begin
            ok_inc = 1'b1;
            exp_d  = exp_q + ONE;
          end else begin
            err_inc = 1'b1;
            err_d   = 1'b1;
            if (!err_q) begin
              err_exp_d = exp_q;
              err_got_d = c_data;
            end
            exp_d = c_data + ONE;
            if (halt_on_err != 0) state_d = HALT;
          end
        end
        default: ;
      endcase
    end
  end

  sd_sat_cnt #(.cnt_width(cnt_width)) u_ok_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (ok_inc),
    .cnt   (ok_cnt)
  );

  sd_sat_cnt #(.cnt_width(cnt_width)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (err_inc),
    .cnt   (err_cnt)
  );

  assign err     = err_q;
  assign err_exp = err_exp_q;
  assign err_got = err_got_q;

endmodule
